// File: rtl/mcs4_pkg.sv
// Shared definitions for the MCS-4 bus tracer: phase encodings, trace record
// layout and the phase-advance helper.
package mcs4_pkg;

  localparam logic [3:0] PH_A1       = 4'd0;
  localparam logic [3:0] PH_A2       = 4'd1;
  localparam logic [3:0] PH_A3       = 4'd2;
  localparam logic [3:0] PH_M1       = 4'd3;
  localparam logic [3:0] PH_M2       = 4'd4;
  localparam logic [3:0] PH_X1       = 4'd5;
  localparam logic [3:0] PH_X2       = 4'd6;
  localparam logic [3:0] PH_X3       = 4'd7;
  localparam logic [3:0] PH_UNLOCKED = 4'd8;

  localparam int unsigned REC_W = 21;

  typedef struct packed {
    logic        cmrom;
    logic [11:0] addr;
    logic [7:0]  opcode;
  } trace_rec_t;

  function automatic logic [3:0] next_phase(input logic [3:0] ph);
    case (ph)
      PH_A1:   return PH_A2;
      PH_A2:   return PH_A3;
      PH_A3:   return PH_M1;
      PH_M1:   return PH_M2;
      PH_M2:   return PH_X1;
      PH_X1:   return PH_X2;
      PH_X2:   return PH_X3;
      PH_X3:   return PH_A1;
      default: return PH_UNLOCKED;
    endcase
  endfunction

endpackage

// File: rtl/mcs4_bus_trace_if.sv
// Trace record stream: valid/ready handshake carrying one fetched instruction.
interface mcs4_bus_trace_if;
  logic        trace_valid;
  logic        trace_ready;
  logic [11:0] trace_addr;
  logic [7:0]  trace_opcode;
  logic        trace_cmrom;

  modport master (
    output trace_valid, trace_addr, trace_opcode, trace_cmrom,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_addr, trace_opcode, trace_cmrom,
    output trace_ready
  );
endinterface

// File: rtl/mcs4_trace_fifo.sv
// First-word-fall-through record buffer with sticky overflow on dropped pushes.
module mcs4_trace_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, pop, wr_en;

  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = out_valid & pop_ready;
  // A pop on the same edge frees the slot, so a push to a full buffer still lands.
  assign wr_en     = push & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (push && !wr_en) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mcs4_bus_trace.sv
// Passive 4004 bus observer: tracks the 8-phase instruction cycle from SYNC and
// clk2 falling edges, captures fetch address/opcode and buffers them as records.
module mcs4_bus_trace
  import mcs4_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    sysclk,
  input  logic                    reset_n,
  input  logic                    clk1,
  input  logic                    clk2,
  input  logic                    sync,
  input  logic                    cmrom,
  input  logic [3:0]              data,
  mcs4_bus_trace_if.master        trace,
  output logic                    overflow,
  output logic                    locked
);

  logic       clk2_q;
  logic [3:0] phase;
  logic       adv;
  logic       push_q;
  trace_rec_t rec;
  trace_rec_t head;

  // clk2 falling edge, ignored when clk1 overlaps it.
  assign adv    = clk2_q & ~clk2 & ~clk1;
  assign locked = (phase != PH_UNLOCKED);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      clk2_q <= 1'b0;
      phase  <= PH_UNLOCKED;
      rec    <= '0;
      push_q <= 1'b0;
    end else begin
      clk2_q <= clk2;
      // Only an uninterrupted A1..M2 run reaches an M2 tick without SYNC.
      push_q <= adv && !sync && (phase == PH_M2);
      if (adv) begin
        if (phase == PH_UNLOCKED || phase == PH_X3) begin
          phase <= sync ? PH_A1 : PH_UNLOCKED;
        end else if (sync) begin
          phase <= PH_A1;
        end else begin
          phase <= next_phase(phase);
          case (phase)
            PH_A1: rec.addr[3:0]   <= data;
            PH_A2: rec.addr[7:4]   <= data;
            PH_A3: begin
              rec.addr[11:8] <= data;
              rec.cmrom      <= cmrom;
            end
            PH_M1: rec.opcode[7:4] <= data;
            PH_M2: rec.opcode[3:0] <= data;
            default: ;
          endcase
        end
      end
    end
  end

  mcs4_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .push      (push_q),
    .push_data (rec),
    .pop_ready (trace.trace_ready),
    .out_valid (trace.trace_valid),
    .out_data  (head),
    .overflow  (overflow)
  );

  assign trace.trace_addr   = head.addr;
  assign trace.trace_opcode = head.opcode;
  assign trace.trace_cmrom  = head.cmrom;

endmodule

// File: tb/tb_mcs4_bus_trace.sv
// Bench for mcs4_bus_trace: directed 4004 bus cycles, an instruction-level
// reference model compared every cycle, and literal record checks.
module tb_mcs4_bus_trace;

  localparam int DEPTH = 4;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk1 = 1'b0, clk2 = 1'b0, sync = 1'b0, cmrom = 1'b0;
  logic [3:0] data = 4'h0;
  logic       overflow, locked;

  mcs4_bus_trace_if tif ();

  mcs4_bus_trace #(.FIFO_DEPTH(DEPTH)) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .clk1     (clk1),
    .clk2     (clk2),
    .sync     (sync),
    .cmrom    (cmrom),
    .data     (data),
    .trace    (tif),
    .overflow (overflow),
    .locked   (locked)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int last_tick_cyc = 0, m2_cyc = 0, rise_cyc = 0;
  bit exp_tick = 1'b0;
  bit prev_v = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Reference model: instruction-cycle position, captured nibbles, record queue.
  bit          m_locked = 1'b0;
  int          m_idx = 0;
  logic [3:0]  m_nib [5];
  logic        m_cm = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_ovf = 1'b0;
  logic [20:0] m_q [$];

  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      m_locked = 1'b0;
      m_idx    = 0;
      m_pend   = 1'b0;
      m_ovf    = 1'b0;
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && tif.trace_ready) void'(m_q.pop_front());
      if (m_pend) begin
        if (m_q.size() < DEPTH)
          m_q.push_back({m_cm, m_nib[2], m_nib[1], m_nib[0], m_nib[3], m_nib[4]});
        else
          m_ovf = 1'b1;
        m_pend = 1'b0;
      end
      if (exp_tick) begin
        if (!m_locked) begin
          if (sync) begin m_locked = 1'b1; m_idx = 0; end
        end else if (m_idx == 7) begin
          if (sync) m_idx = 0;
          else      m_locked = 1'b0;
        end else if (sync) begin
          m_idx = 0;
        end else begin
          if (m_idx < 5) m_nib[m_idx] = data;
          if (m_idx == 2) m_cm = cmrom;
          if (m_idx == 4) m_pend = 1'b1;
          m_idx++;
        end
      end
    end
  end

  logic [23:0] cmp_exp, cmp_act;
  logic [20:0] cmp_head;

  always @(negedge sysclk) begin
    if (reset_n) begin
      cmp_head = (m_q.size() != 0) ? m_q[0] : 21'h0;
      cmp_exp  = {m_q.size() != 0, cmp_head, m_ovf, m_locked};
      cmp_act  = {tif.trace_valid,
                  tif.trace_valid ? {tif.trace_cmrom, tif.trace_addr, tif.trace_opcode} : 21'h0,
                  overflow, locked};
      n_cmp++;
      if (cmp_act !== cmp_exp) begin
        n_fail++;
        $display("FAIL cycle_model @%0d: dut=%h model=%h", cyc, cmp_act, cmp_exp);
      end
    end
    if (tif.trace_valid && !prev_v) rise_cyc = cyc;
    prev_v = tif.trace_valid;
  end

  logic [20:0] got [$];

  always @(posedge sysclk) begin
    if (reset_n && tif.trace_valid && tif.trace_ready)
      got.push_back({tif.trace_cmrom, tif.trace_addr, tif.trace_opcode});
  end

  function automatic logic [20:0] mk(input logic cm, input logic [11:0] a, input logic [7:0] op);
    return {cm, a, op};
  endfunction

  function automatic logic [20:0] got_at(input int i);
    return (got.size() > i) ? got[i] : 21'h1FFFFF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus phase: clk1 pulse, clk2 pulse, clk2 falls (tick), settle cycle.
  task automatic phase(input logic [3:0] d, input logic s, input logic c,
                       input bit bad = 1'b0, input bit pulse = 1'b0);
    @(negedge sysclk); clk1 = 1'b1; clk2 = 1'b0; data = d; sync = s; cmrom = c; exp_tick = 1'b0;
    @(negedge sysclk); clk1 = 1'b0;
    @(negedge sysclk); clk2 = 1'b1; clk1 = bad;
    @(negedge sysclk); clk2 = 1'b0; exp_tick = !bad; last_tick_cyc = cyc;
    @(negedge sysclk); exp_tick = 1'b0; clk1 = 1'b0;
    if (pulse) tif.trace_ready = 1'b1;
    if (pulse) begin
      @(negedge sysclk); tif.trace_ready = 1'b0;
    end
  endtask

  task automatic instr(input logic [11:0] a, input logic [7:0] op, input logic cm,
                       input logic sx3, input bit pulse = 1'b0);
    phase(a[3:0], 1'b0, 1'b0);
    phase(a[7:4], 1'b0, 1'b0);
    phase(a[11:8], 1'b0, cm);
    phase(op[7:4], 1'b0, 1'b0);
    phase(op[3:0], 1'b0, 1'b0, 1'b0, pulse);
    m2_cyc = last_tick_cyc;
    phase(4'h0, 1'b0, 1'b0);
    phase(4'h0, 1'b0, 1'b0);
    phase(4'h0, sx3, 1'b0);
  endtask

  task automatic drain();
    tif.trace_ready = 1'b1;
    repeat (8) @(negedge sysclk);
    tif.trace_ready = 1'b0;
  endtask

  initial begin
    tif.trace_ready = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_valid", tif.trace_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fields", {tif.trace_cmrom, tif.trace_addr, tif.trace_opcode}, 0);
    reset_n = 1'b1;
    @(negedge sysclk);

    // Basic fetch with consumer always ready
    tif.trace_ready = 1'b1;
    got.delete();
    phase(4'h0, 1'b1, 1'b0);
    chk("first_lock", locked, 1);
    instr(12'h234, 8'hD5, 1'b1, 1'b1);
    chk("basic_count", got.size(), 1);
    chk("basic_rec", got_at(0), mk(1'b1, 12'h234, 8'hD5));
    chk("push_latency", rise_cyc - m2_cyc, 2);

    // A tick overlapping clk1 is ignored
    got.delete();
    phase(4'h7, 1'b0, 1'b0);
    phase(4'h6, 1'b0, 1'b0);
    phase(4'hF, 1'b0, 1'b0, 1'b1);
    phase(4'h5, 1'b0, 1'b0);
    phase(4'hA, 1'b0, 1'b0);
    phase(4'hB, 1'b0, 1'b0);
    phase(4'h0, 1'b0, 1'b0);
    phase(4'h0, 1'b0, 1'b0);
    phase(4'h0, 1'b1, 1'b0);
    chk("clk1_rec", got_at(0), mk(1'b0, 12'h567, 8'hAB));

    // Lost SYNC at X3, no record while unlocked, relock
    got.delete();
    instr(12'h111, 8'h1A, 1'b0, 1'b0);
    chk("lost_sync_unlocked", locked, 0);
    instr(12'h222, 8'h2B, 1'b1, 1'b0);
    chk("still_unlocked", locked, 0);
    phase(4'h0, 1'b1, 1'b0);
    instr(12'h333, 8'h3C, 1'b0, 1'b1);
    chk("relock_count", got.size(), 2);
    chk("relock_rec0", got_at(0), mk(1'b0, 12'h111, 8'h1A));
    chk("relock_rec1", got_at(1), mk(1'b0, 12'h333, 8'h3C));

    // SYNC at M1 aborts the cycle
    got.delete();
    phase(4'h1, 1'b0, 1'b0);
    phase(4'h2, 1'b0, 1'b0);
    phase(4'h3, 1'b0, 1'b1);
    phase(4'h4, 1'b1, 1'b0);
    instr(12'h456, 8'h78, 1'b1, 1'b1);
    chk("resync_count", got.size(), 1);
    chk("resync_rec", got_at(0), mk(1'b1, 12'h456, 8'h78));

    // Full FIFO with push and pop on the same edge
    tif.trace_ready = 1'b0;
    got.delete();
    for (int k = 0; k < 4; k++)
      instr(12'h5A0 + 12'(k), 8'hC0 + 8'(k), k[0], 1'b1);
    instr(12'h5A4, 8'hC4, 1'b0, 1'b1, 1'b1);
    chk("fullpp_overflow", overflow, 0);
    chk("fullpp_popped", got.size(), 1);
    chk("fullpp_rec0", got_at(0), mk(1'b0, 12'h5A0, 8'hC0));
    drain();
    chk("fullpp_total", got.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("fullpp_order", got_at(k), mk(k[0], 12'h5A0 + 12'(k), 8'hC0 + 8'(k)));

    // Five cycles with no consumer: fifth dropped
    got.delete();
    for (int k = 0; k < 5; k++)
      instr(12'h7B0 + 12'(k), 8'hE0 + 8'(k), 1'b1, 1'b1);
    chk("ovf_set", overflow, 1);
    chk("ovf_held_valid", tif.trace_valid, 1);
    chk("ovf_none_popped", got.size(), 0);
    drain();
    chk("ovf_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("ovf_order", got_at(k), mk(1'b1, 12'h7B0 + 12'(k), 8'hE0 + 8'(k)));
    chk("ovf_empty", tif.trace_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset during M1 with two buffered records
    got.delete();
    instr(12'h8D0, 8'h90, 1'b0, 1'b1);
    instr(12'h8D1, 8'h91, 1'b1, 1'b1);
    phase(4'h2, 1'b0, 1'b0);
    phase(4'h4, 1'b0, 1'b0);
    phase(4'h6, 1'b0, 1'b1);
    @(negedge sysclk); clk1 = 1'b1; data = 4'h9;
    @(negedge sysclk); clk1 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", tif.trace_valid, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_locked", locked, 0);
    chk("arst_fields", {tif.trace_cmrom, tif.trace_addr, tif.trace_opcode}, 0);
    @(negedge sysclk);
    @(negedge sysclk); reset_n = 1'b1;
    tif.trace_ready = 1'b1;
    instr(12'hEEE, 8'hEE, 1'b0, 1'b0);
    chk("post_rst_unlocked", locked, 0);
    phase(4'h0, 1'b1, 1'b0);
    instr(12'hFED, 8'hCB, 1'b1, 1'b1);
    chk("post_rst_count", got.size(), 1);
    chk("post_rst_rec", got_at(0), mk(1'b1, 12'hFED, 8'hCB));

    repeat (4) @(negedge sysclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
